// File: rtl/matmul_pkg.sv
// Shared constants and the drain state encoding for the 4x4 int8 matmul
// result path.
package matmul_pkg;

   localparam int MM_DIM   = 4;
   localparam int MM_ACC_W = 32;
   localparam int MM_OUT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } drain_state_e;

endpackage

// File: rtl/matmul_result_drain_if.sv
// Row-per-beat valid/ready stream carrying the requantized result matrix.
interface matmul_result_drain_if
   import matmul_pkg::*;
#(
   parameter int DIM   = MM_DIM,
   parameter int OUT_W = MM_OUT_W
) ();

   logic                   out_valid;
   logic                   out_ready;
   logic [DIM*OUT_W-1:0]   out_row;
   logic [1:0]             out_row_idx;
   logic                   out_last;

   modport master (
      output out_valid,
      output out_row,
      output out_row_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_row,
      input  out_row_idx,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/requant_sat.sv
// Combinational requantizer: optional ReLU, round-half-up arithmetic right
// shift, then saturation of one accumulator element to OUT_W bits.
module requant_sat
   import matmul_pkg::*;
#(
   parameter int ACC_W = MM_ACC_W,
   parameter int OUT_W = MM_OUT_W
) (
   input  logic signed [ACC_W-1:0] c,
   input  logic        [4:0]       shift,
   input  logic                    relu_en,
   output logic signed [OUT_W-1:0] y
);

   // Two guard bits keep c + 2^(shift-1) from wrapping for shift=31.
   localparam int EXT_W = ACC_W + 2;

   function automatic logic signed [EXT_W-1:0] round_shift(
      input logic signed [EXT_W-1:0] x,
      input logic        [4:0]       sh
   );
      logic signed [EXT_W-1:0] bias;
      bias = '0;
      if (sh != 5'd0) bias[sh - 5'd1] = 1'b1;
      return (x + bias) >>> sh;
   endfunction

   function automatic logic signed [OUT_W-1:0] saturate(
      input logic signed [EXT_W-1:0] v
   );
      logic signed [EXT_W-1:0] hi;
      logic signed [EXT_W-1:0] lo;
      hi = EXT_W'((1 << (OUT_W - 1)) - 1);
      lo = -hi - EXT_W'(1);
      if (v > hi)      return hi[OUT_W-1:0];
      else if (v < lo) return lo[OUT_W-1:0];
      else             return v[OUT_W-1:0];
   endfunction

   logic signed [EXT_W-1:0] x_ext;

   always_comb begin
      if (relu_en && c[ACC_W-1]) x_ext = '0;
      else                       x_ext = {{2{c[ACC_W-1]}}, c};
      y = saturate(round_shift(x_ext, shift));
   end

endmodule

// File: rtl/matmul_result_drain.sv
// Waits a fixed latency after a multiplier launch, snapshots and requantizes
// the 4x4 result, then streams it out one row per valid/ready beat.
module matmul_result_drain
   import matmul_pkg::*;
#(
   parameter int DIM     = MM_DIM,
   parameter int ACC_W   = MM_ACC_W,
   parameter int OUT_W   = MM_OUT_W,
   parameter int LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mm_valid,
   input  logic signed [ACC_W-1:0] c_in [DIM][DIM],
   input  logic        [4:0]       shift,
   input  logic                    relu_en,
   matmul_result_drain_if.master   dout,
   output logic                    busy,
   output logic                    drop_err
);

   localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [1:0]       LAST_ROW = 2'(DIM - 1);

   drain_state_e             state_q,   state_d;
   logic [CNT_W-1:0]         cnt_q,     cnt_d;
   logic [4:0]               shift_q,   shift_d;
   logic                     relu_q,    relu_d;
   logic [1:0]               row_idx_q, row_idx_d;
   logic                     drop_q,    drop_d;
   logic signed [OUT_W-1:0]  hold_q [DIM][DIM];
   logic signed [OUT_W-1:0]  hold_d [DIM][DIM];
   logic signed [OUT_W-1:0]  rq     [DIM][DIM];
   logic                     send;
   logic                     accept;
   logic [DIM*OUT_W-1:0]     row_flat;

   for (genvar r = 0; r < DIM; r++) begin : g_row
      for (genvar col = 0; col < DIM; col++) begin : g_col
         requant_sat #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
         ) u_rq (
            .c       (c_in[r][col]),
            .shift   (shift_q),
            .relu_en (relu_q),
            .y       (rq[r][col])
         );
      end
   end

   assign send = (state_q == SEND);

   // A launch is taken in IDLE, or on the very edge that retires row 3.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      relu_d    = relu_q;
      row_idx_d = row_idx_q;
      hold_d    = hold_q;
      accept    = mm_valid && ((state_q == IDLE) ||
                  (send && dout.out_ready && (row_idx_q == LAST_ROW)));
      drop_d    = mm_valid && !accept;

      if (accept) begin
         shift_d = shift;
         relu_d  = relu_en;
         cnt_d   = CNT_LOAD;
      end

      case (state_q)
         IDLE: if (accept) state_d = WAIT;
         WAIT: begin
            if (cnt_q == '0) begin
               hold_d    = rq;
               row_idx_d = 2'd0;
               state_d   = SEND;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         SEND: begin
            if (dout.out_ready) begin
               if (row_idx_q == LAST_ROW) state_d = accept ? WAIT : IDLE;
               else                       row_idx_d = row_idx_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
         row_idx_q <= 2'd0;
         drop_q    <= 1'b0;
         hold_q    <= '{default: '0};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         relu_q    <= relu_d;
         row_idx_q <= row_idx_d;
         drop_q    <= drop_d;
         hold_q    <= hold_d;
      end
   end

   always_comb begin
      row_flat = '0;
      for (int col = 0; col < DIM; col++)
         row_flat[col*OUT_W +: OUT_W] = hold_q[row_idx_q][col];
   end

   assign dout.out_valid   = send;
   assign dout.out_row     = row_flat;
   assign dout.out_row_idx = row_idx_q;
   assign dout.out_last    = send && (row_idx_q == LAST_ROW);
   assign busy             = (state_q != IDLE);
   assign drop_err         = drop_q;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Randomized bench for matmul_result_drain: a queue of expected row beats is
// filled from an arithmetic requant model and drained by a stream monitor.
module tb_matmul_result_drain;
   import matmul_pkg::*;

   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              mm_valid;
   logic signed [31:0] c_in [4][4];
   logic [4:0]        shift;
   logic              relu_en;
   logic              busy;
   logic              drop_err;

   matmul_result_drain_if dif ();

   matmul_result_drain #(.LATENCY(LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .mm_valid (mm_valid),
      .c_in     (c_in),
      .shift    (shift),
      .relu_en  (relu_en),
      .dout     (dif),
      .busy     (busy),
      .drop_err (drop_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [31:0] row;
      logic [1:0]  idx;
   } beat_t;

   beat_t exp_q[$];
   int    mat [4][4];

   function automatic logic [7:0] ref_q(input int c, input int sh, input bit relu);
      longint x;
      x = c;
      if (relu && x < 0) x = 0;
      if (sh > 0) x = x + (longint'(1) << (sh - 1));
      x = x >>> sh;
      if (x > 127)  x = 127;
      if (x < -128) x = -128;
      return x[7:0];
   endfunction

   function automatic logic [31:0] row_of(input int r, input int sh, input bit relu);
      logic [31:0] v;
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = ref_q(mat[r][k], sh, relu);
      return v;
   endfunction

   task automatic push_matrix(input int sh, input bit relu);
      beat_t b;
      for (int r = 0; r < 4; r++) begin
         b.row = row_of(r, sh, relu);
         b.idx = 2'(r);
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_mat();
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            mat[r][k] = $signed($urandom) >>> $urandom_range(0, 31);
   endtask

   task automatic fill_mat(input int v);
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) mat[r][k] = v;
   endtask

   task automatic drive_mat();
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) c_in[r][k] = mat[r][k];
   endtask

   task automatic launch(input int sh, input bit relu);
      drive_mat();
      shift    = 5'(sh);
      relu_en  = relu;
      mm_valid = 1'b1;
      push_matrix(sh, relu);
      tick();
      mm_valid = 1'b0;
   endtask

   task automatic wait_row(input int idx);
      bit found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (dif.out_valid && dif.out_row_idx == 2'(idx)) found = 1'b1;
         else tick();
      end
      check_val("wait_row", found, 1);
   endtask

   task automatic wait_idle(input bit rand_rdy);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (!busy && exp_q.size() == 0) done = 1'b1;
         else begin
            if (rand_rdy) dif.out_ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      check_val("drain_done", done, 1);
   endtask

   // Stream monitor: sampled on the falling edge, between driver updates.
   bit          hold_pend = 1'b0;
   logic [31:0] prev_row;
   logic [1:0]  prev_idx;
   beat_t       mb;

   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check_val("hold_valid", dif.out_valid, 1);
            check_val("hold_row", dif.out_row, prev_row);
            check_val("hold_idx", dif.out_row_idx, prev_idx);
         end
         if (dif.out_valid && dif.out_ready) begin
            check_val("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mb = exp_q.pop_front();
               check_val("beat_row", dif.out_row, mb.row);
               check_val("beat_idx", dif.out_row_idx, mb.idx);
               check_val("beat_last", dif.out_last, mb.idx == 2'd3);
            end
         end
         hold_pend = dif.out_valid && !dif.out_ready;
         prev_row  = dif.out_row;
         prev_idx  = dif.out_row_idx;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r1;
      rst = 1'b1;
      mm_valid = 1'b0;
      shift = '0;
      relu_en = 1'b0;
      dif.out_ready = 1'b0;
      fill_mat(0);
      drive_mat();
      repeat (3) tick();
      check_val("rst_valid", dif.out_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_drop", drop_err, 0);
      check_val("rst_row", dif.out_row, 0);
      check_val("rst_idx", dif.out_row_idx, 0);
      check_val("rst_last", dif.out_last, 0);
      rst = 1'b0;
      tick();

      // Basic drain with exact capture latency.
      fill_mat(300);
      dif.out_ready = 1'b1;
      launch(2, 0);
      for (int i = 0; i < LAT; i++) begin
         check_val("lat_valid_low", dif.out_valid, 0);
         check_val("lat_busy", busy, 1);
         tick();
      end
      check_val("lat_valid_high", dif.out_valid, 1);
      check_val("basic_row0", dif.out_row, 32'h4B4B4B4B);
      check_val("basic_idx0", dif.out_row_idx, 0);
      wait_idle(0);
      check_val("basic_idle_valid", dif.out_valid, 0);
      check_val("basic_drop", drop_err, 0);

      // Saturation and ReLU.
      rand_mat();
      mat[0][0] = 1000; mat[0][1] = -1000; mat[0][2] = -5; mat[0][3] = 6;
      launch(0, 0);
      wait_row(0);
      check_val("sat_row0", dif.out_row, 32'h06FB807F);
      wait_idle(0);
      launch(0, 1);
      wait_row(0);
      check_val("relu_row0", dif.out_row, 32'h0600007F);
      wait_idle(0);

      // Rounding, including the widest shift on the largest value.
      mat[0][0] = 6; mat[0][1] = -6; mat[0][2] = 5; mat[0][3] = -5;
      launch(2, 0);
      wait_row(0);
      check_val("round_row0", dif.out_row, 32'hFF01FF02);
      wait_idle(0);
      fill_mat(32'h7FFFFFFF);
      launch(31, 0);
      wait_row(0);
      check_val("shift31_row0", dif.out_row, 32'h01010101);
      wait_idle(0);

      // Backpressure on row 1.
      rand_mat();
      r1 = row_of(1, 3, 1);
      dif.out_ready = 1'b0;
      launch(3, 1);
      wait_row(0);
      dif.out_ready = 1'b1;
      tick();
      dif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_val("bp_valid", dif.out_valid, 1);
         check_val("bp_idx", dif.out_row_idx, 1);
         check_val("bp_row", dif.out_row, r1);
         tick();
      end
      dif.out_ready = 1'b1;
      tick();
      check_val("bp_next_idx", dif.out_row_idx, 2);
      wait_idle(0);

      // Relaunch on the row-3 handshake edge.
      rand_mat();
      launch(4, 0);
      wait_row(3);
      rand_mat();
      drive_mat();
      shift = 5'd1;
      relu_en = 1'b1;
      mm_valid = 1'b1;
      push_matrix(1, 1);
      tick();
      mm_valid = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         check_val("b2b_valid_low", dif.out_valid, 0);
         check_val("b2b_drop", drop_err, 0);
         check_val("b2b_busy", busy, 1);
         tick();
      end
      check_val("b2b_valid_high", dif.out_valid, 1);
      check_val("b2b_idx0", dif.out_row_idx, 0);
      wait_idle(0);

      // Collision while row 1 is held.
      rand_mat();
      r1 = row_of(1, 5, 0);
      dif.out_ready = 1'b0;
      launch(5, 0);
      wait_row(0);
      dif.out_ready = 1'b1;
      tick();
      dif.out_ready = 1'b0;
      rand_mat();
      drive_mat();
      shift = 5'd9;
      mm_valid = 1'b1;
      tick();
      mm_valid = 1'b0;
      check_val("coll_drop", drop_err, 1);
      check_val("coll_idx", dif.out_row_idx, 1);
      check_val("coll_row", dif.out_row, r1);
      tick();
      check_val("coll_drop_clear", drop_err, 0);
      dif.out_ready = 1'b1;
      wait_idle(0);

      // Collision while waiting for the result.
      rand_mat();
      launch(6, 1);
      mm_valid = 1'b1;
      tick();
      mm_valid = 1'b0;
      check_val("wait_coll_drop", drop_err, 1);
      wait_idle(0);

      // Reset in the middle of a drain.
      rand_mat();
      dif.out_ready = 1'b0;
      launch(2, 0);
      wait_row(0);
      dif.out_ready = 1'b1;
      wait_row(2);
      dif.out_ready = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      check_val("mid_rst_valid", dif.out_valid, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_idx", dif.out_row_idx, 0);
      rand_mat();
      r1 = row_of(0, 7, 0);
      dif.out_ready = 1'b1;
      launch(7, 0);
      wait_row(0);
      check_val("post_rst_row0", dif.out_row, r1);
      wait_idle(0);

      // Random matrices, parameters and backpressure.
      for (int n = 0; n < 25; n++) begin
         rand_mat();
         launch(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         wait_idle(1);
      end

      check_val("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Downstream stage of the 4x4 int8 matrix multiplier.
- Is told when the multiplier was launched, waits a fixed latency, then snapshots the 4x4 int32 result array.
- Requantizes each element to int8 with optional ReLU, rounding right shift and saturation.
- Streams the result out one row per beat over a valid/ready interface, so the multiplier can be relaunched while rows drain.

Parameters:
- DIM, 4, matrix dimension (rows/cols); only 4 is supported.
- ACC_W, 32, width of each signed result element.
- OUT_W, 8, width of each requantized signed element.
- LATENCY, 2, cycles from the launch edge to the edge where c_in is sampled; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mm_valid  in  1  launch pulse, the same signal driven to the multiplier's valid.
- c_in  in  signed [ACC_W-1:0] [0:DIM-1][0:DIM-1]  multiplier result array.
- shift  in  5  right-shift amount; latched when a launch is accepted.
- relu_en  in  1  clamp negatives to 0 before the shift; latched when a launch is accepted.
- out_valid  out  1  a row beat is presented.
- out_ready  in  1  downstream accepts the beat.
- out_row  out  DIM*OUT_W  row elements, column 0 in bits [7:0], column 3 in bits [31:24].
- out_row_idx  out  2  row index of the current beat.
- out_last  out  1  high on the row-3 beat.
- busy  out  1  state != IDLE.
- drop_err  out  1  one-cycle pulse when a launch is ignored.

Behaviour:
- Reset: state IDLE, latency counter 0; out_valid, out_row, out_row_idx, out_last, busy, drop_err all 0; holding registers cleared. A reset mid-operation discards the pending or partially drained matrix.
- States:
  - IDLE: mm_valid=1 latches shift and relu_en, loads the counter with LATENCY-1, goes to WAIT.
  - WAIT: the counter decrements each cycle. On the edge where the counter is 0, c_in is requantized and stored into 16 holding registers, out_row_idx is set to 0, and the state goes to SEND. c_in is therefore sampled exactly LATENCY edges after the launch edge.
  - SEND: out_valid=1 and out_row = requantized row out_row_idx. Each out_valid&&out_ready edge advances the row index. The handshake on row 3 ends the matrix: go to IDLE, or go to WAIT if mm_valid=1 on that same edge (launch accepted, shift/relu relatched).
- Handshake rules:
  - out_valid never drops and out_row/out_row_idx never change without a handshake.
  - out_ready may be high while out_valid is low with no effect.
  - Minimum drain is 4 cycles with out_ready held high.
- Launch collision: mm_valid in WAIT or SEND (other than the row-3 handshake case above) is ignored and drop_err is high for the following cycle. The ongoing matrix is unaffected.
- Requant per element, computed at least 34 bits wide:
  - x = c; if relu_en and x<0 then x=0.
  - If shift>0, x = x + (1<<(shift-1)) for round-half-up.
  - y = x >>> shift (arithmetic).
  - Saturate y to [-128,127].
- Throughput: one matrix per LATENCY+4 cycles minimum, reached by relaunching on the row-3 handshake.

Decomposition:
- Package matmul_pkg: DIM, ACC_W, OUT_W constants; drain state enum {IDLE, WAIT, SEND}.
- Sub-module requant_sat: combinational, one element in (ACC_W), shift, relu_en; int8 out. Instantiated DIM*DIM times in a generate loop ahead of the holding registers.

Test Plan:
- Basic drain: LATENCY=2, c_in all 300, shift=2, relu_en=0, out_ready=1, launch pulse -> first out_valid 3 cycles after the launch edge; 4 beats, each out_row=0x4B4B4B4B; out_row_idx 0..3; out_last only on beat 3; busy low after.
- Saturation/ReLU: c[0][0..3]={1000,-1000,-5,6}, shift=0 -> row 0 = {127,-128,-5,6}. Same with relu_en=1 -> {127,0,0,6}.
- Rounding: c row 0 {6,-6,5,-5}, shift=2 -> {2,-1,1,-1}. Also shift=31, c=0x7FFFFFFF -> 1 (no overflow in the add).
- Backpressure: out_ready low for 3 cycles while row 1 is presented -> out_valid stays high and out_row/out_row_idx hold row 1 for all 3 cycles; row 2 appears only after the handshake.
- Back-to-back/collision:
  - mm_valid on the row-3 handshake edge -> the second matrix is captured LATENCY edges later with no drop_err.
  - mm_valid during row 1 -> drop_err one cycle and the output is unchanged.
- Reset mid-SEND at row 2 -> next cycle out_valid=0, busy=0; a new launch drains a fresh matrix starting at row 0.
